// File: rtl/axi4lite_gp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_gp_pkg
//  Purpose  : Shared response codes, FSM encodings and address decode helper
//             for the AXI4-Lite general-purpose register slave.
//  Revision : 1.0  initial release
// ============================================================================
package axi4lite_gp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE     = 2'd0,
        W_GOT_ADDR = 2'd1,
        W_GOT_DATA = 2'd2,
        W_RESP     = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic       in_range;
        logic [3:0] idx;
    } addr_dec_t;

    // The register window spans num_regs*4 bytes (a power of two), so range
    // membership reduces to comparing everything above the window offset.
    function automatic addr_dec_t decode_addr(input logic [63:0] addr,
                                              input logic [63:0] base,
                                              input int unsigned num_regs);
        addr_dec_t   d;
        logic [63:0] span_mask;
        span_mask  = 64'(num_regs) * 64'd4 - 64'd1;
        d.in_range = ((addr & ~span_mask) == (base & ~span_mask));
        d.idx      = 4'((addr >> 2) & (64'(num_regs) - 64'd1));
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_gp_reg_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_gp_reg_slave_if
//  Purpose  : AXI4-Lite bus bundle with master and slave modports.
//  Revision : 1.0  initial release
// ============================================================================
interface axi4lite_gp_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axi4lite_gp_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_gp_wr_ctrl
//  Purpose  : Write-channel FSM; joins independent AW/W handshakes and emits a
//             one-cycle commit strobe with register index, data and strobes.
//  Revision : 1.0  initial release
// ============================================================================
module axi4lite_gp_wr_ctrl
    import axi4lite_gp_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          IDX_W      = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [ADDR_WIDTH-1:0] i_awaddr,
    input  wire logic                  i_awvalid,
    output logic                       o_awready,
    input  wire logic [31:0]           i_wdata,
    input  wire logic [3:0]            i_wstrb,
    input  wire logic                  i_wvalid,
    output logic                       o_wready,
    output logic [1:0]                 o_bresp,
    output logic                       o_bvalid,
    input  wire logic                  i_bready,
    output logic                       o_commit,
    output logic [IDX_W-1:0]           o_commit_idx,
    output logic [31:0]                o_commit_data,
    output logic [3:0]                 o_commit_strb
);

    wr_state_t             r_state;
    wr_state_t             w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic [3:0]            r_strb;
    logic [1:0]            r_bresp;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] w_eff_addr;
    logic [31:0]           w_eff_data;
    logic [3:0]            w_eff_strb;
    addr_dec_t             w_dec;

    assign o_awready = ~rst & ((r_state == W_IDLE) || (r_state == W_GOT_DATA));
    assign o_wready  = ~rst & ((r_state == W_IDLE) || (r_state == W_GOT_ADDR));
    assign o_bvalid  = (r_state == W_RESP);
    assign o_bresp   = r_bresp;
    assign w_aw_hs   = i_awvalid & o_awready;
    assign w_w_hs    = i_wvalid & o_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= W_IDLE;
        else     r_state <= w_next;
    end

    // Whichever half arrived first comes from the capture registers.
    always_comb begin
        w_next     = r_state;
        w_fire     = 1'b0;
        w_eff_addr = i_awaddr;
        w_eff_data = i_wdata;
        w_eff_strb = i_wstrb;
        case (r_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_fire = 1'b1;
                    w_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_next = W_GOT_ADDR;
                end else if (w_w_hs) begin
                    w_next = W_GOT_DATA;
                end
            end
            W_GOT_ADDR: begin
                w_eff_addr = r_addr;
                if (w_w_hs) begin
                    w_fire = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_GOT_DATA: begin
                w_eff_data = r_data;
                w_eff_strb = r_strb;
                if (w_aw_hs) begin
                    w_fire = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (i_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign w_dec         = decode_addr(64'(w_eff_addr), 64'(BASE_ADDR), NUM_REGS);
    assign o_commit      = w_fire & w_dec.in_range;
    assign o_commit_idx  = IDX_W'(w_dec.idx);
    assign o_commit_data = w_eff_data;
    assign o_commit_strb = w_eff_strb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_strb  <= '0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (r_state == W_IDLE && w_aw_hs && !w_w_hs) r_addr <= i_awaddr;
            if (r_state == W_IDLE && w_w_hs && !w_aw_hs) begin
                r_data <= i_wdata;
                r_strb <= i_wstrb;
            end
            if (w_fire) r_bresp <= w_dec.in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_gp_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_gp_reg_slave
//  Purpose  : AXI4-Lite register bank: C_NUM_REGS x 32-bit R/W registers,
//             byte strobes, SLVERR outside the register window.
//  Revision : 1.0  initial release
// ============================================================================
module axi4lite_gp_reg_slave
    import axi4lite_gp_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_NUM_REGS         = 4,
    parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000
) (
    input  wire logic                 ACLK,
    input  wire logic                 ARESET,
    axi4lite_gp_reg_slave_if.slave    s_axi,
    output logic [32*C_NUM_REGS-1:0]  reg_out
);

    localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

    logic [31:0]      r_regs [C_NUM_REGS];
    logic             w_commit;
    logic [IDX_W-1:0] w_commit_idx;
    logic [31:0]      w_commit_data;
    logic [3:0]       w_commit_strb;
    rd_state_t        r_rstate;
    rd_state_t        w_rnext;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic             w_ar_hs;
    addr_dec_t        w_rdec;
    logic [IDX_W-1:0] w_ridx;
    logic             w_unused_prot;

    assign w_unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    axi4lite_gp_wr_ctrl #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_REGS   (C_NUM_REGS),
        .BASE_ADDR  (C_BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_wr_ctrl (
        .clk           (ACLK),
        .rst           (ARESET),
        .i_awaddr      (s_axi.AWADDR),
        .i_awvalid     (s_axi.AWVALID),
        .o_awready     (s_axi.AWREADY),
        .i_wdata       (s_axi.WDATA),
        .i_wstrb       (s_axi.WSTRB),
        .i_wvalid      (s_axi.WVALID),
        .o_wready      (s_axi.WREADY),
        .o_bresp       (s_axi.BRESP),
        .o_bvalid      (s_axi.BVALID),
        .i_bready      (s_axi.BREADY),
        .o_commit      (w_commit),
        .o_commit_idx  (w_commit_idx),
        .o_commit_data (w_commit_data),
        .o_commit_strb (w_commit_strb)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int r = 0; r < int'(C_NUM_REGS); r++) r_regs[r] <= '0;
        end else if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_commit_strb[b]) r_regs[w_commit_idx][8*b +: 8] <= w_commit_data[8*b +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < int'(C_NUM_REGS); gi++) begin : g_reg_out
        assign reg_out[32*gi +: 32] = r_regs[gi];
    end

    assign s_axi.ARREADY = ~ARESET & (r_rstate == R_IDLE);
    assign s_axi.RVALID  = (r_rstate == R_DATA);
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;
    assign w_ar_hs       = s_axi.ARVALID & s_axi.ARREADY;
    assign w_rdec        = decode_addr(64'(s_axi.ARADDR), 64'(C_BASE_ADDR), C_NUM_REGS);
    assign w_ridx        = IDX_W'(w_rdec.idx);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_rstate <= R_IDLE;
        else        r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
            R_DATA:  if (s_axi.RREADY) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Sampled with non-blocking semantics, so a same-edge write is not yet visible.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rdec.in_range ? r_regs[w_ridx] : 32'h0;
            r_rresp <= w_rdec.in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_gp_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4lite_gp_reg_slave
//  Purpose  : Self-checking bench with directed and randomized AXI4-Lite traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4lite_gp_reg_slave;

    localparam int          NR   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [32*NR-1:0] reg_out;
    int               n_checks = 0;
    int               n_errors = 0;
    logic [31:0]      model_regs [NR];

    always #5 clk = ~clk;

    axi4lite_gp_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4lite_gp_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_NUM_REGS         (NR),
        .C_BASE_ADDR        (BASE)
    ) dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .s_axi   (bus),
        .reg_out (reg_out)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_in_range(input logic [31:0] a);
        return (a - BASE) < 32'(NR * 4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int idx;
        if (!model_in_range(a)) begin
            resp = 2'b10;
        end else begin
            idx = int'((a - BASE) / 4);
            for (int b = 0; b < 4; b++)
                if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
            resp = 2'b00;
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        if (model_in_range(a)) begin
            d    = model_regs[int'((a - BASE) / 4)];
            resp = 2'b00;
        end else begin
            d    = 32'h0;
            resp = 2'b10;
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model_regs[i];
        return f;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the B handshake.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_stall, input string tag);
        logic [1:0] exp_resp;
        int  cyc, last_hs, b_cyc;
        bit  aw_done, w_done, ok;
        model_write(a, d, s, exp_resp);
        bus.AWADDR = a;
        bus.AWPROT = 3'($urandom);
        bus.WDATA  = d;
        bus.WSTRB  = s;
        bus.BREADY = 1'b0;
        cyc = 0; last_hs = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.AWVALID = !aw_done && (cyc >= aw_dly);
            bus.WVALID  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            if (bus.AWVALID && bus.AWREADY) begin aw_done = 1; last_hs = cyc; end
            if (bus.WVALID && bus.WREADY)   begin w_done = 1;  last_hs = cyc; end
            @(posedge clk); #1;
            cyc++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check_val({tag, " handshakes"}, {aw_done, w_done}, 2'b11);
        if (!(aw_done && w_done)) return;
        b_cyc = cyc; ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.BVALID) begin ok = 1; break; end
            @(posedge clk); #1;
            b_cyc++;
        end
        check_val({tag, " bvalid seen"}, ok, 1'b1);
        if (!ok) return;
        check_val({tag, " b latency"}, b_cyc - last_hs, 1);
        check_val({tag, " bresp"}, bus.BRESP, exp_resp);
        for (int k = 0; k < b_stall; k++) begin
            @(posedge clk); #1;
            bus.AWVALID = 1'b1;
            @(negedge clk);
            check_val({tag, " stall b/aw"}, {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY},
                      {1'b1, exp_resp, 2'b00});
        end
        bus.AWVALID = 1'b0;
        bus.BREADY  = 1'b1;
        @(posedge clk); #1;
        bus.BREADY  = 1'b0;
        check_val({tag, " bvalid drop"}, bus.BVALID, 1'b0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                            input int r_stall, input string tag);
        bit ok;
        bus.ARADDR  = a;
        bus.ARPROT  = 3'($urandom);
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.ARREADY) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.ARVALID = 1'b0;
        check_val({tag, " ar accepted"}, ok, 1'b1);
        if (!ok) return;
        @(negedge clk);
        check_val({tag, " rvalid"}, bus.RVALID, 1'b1);
        check_val({tag, " rdata"}, bus.RDATA, exp_d);
        check_val({tag, " rresp"}, bus.RRESP, exp_r);
        for (int k = 0; k < r_stall; k++) begin
            @(posedge clk); #1;
            bus.ARVALID = 1'b1;
            @(negedge clk);
            check_val({tag, " stall r/ar"}, {bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY},
                      {1'b1, exp_d, exp_r, 1'b0});
        end
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;
        @(posedge clk); #1;
        bus.RREADY  = 1'b0;
    endtask

    task automatic rd_model(input logic [31:0] a, input int r_stall, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        model_read(a, d, r);
        axi_read(a, d, r, r_stall, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] seq_vals [4];
        logic [31:0] a;
        seq_vals = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;

        repeat (2) @(negedge clk);
        check_val("reset ctrl", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                                 bus.BRESP, bus.RRESP}, 9'b0);
        check_val("reset rdata", bus.RDATA, 32'h0);
        check_val("reset reg_out", reg_out, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post reset ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            axi_write(32'(i * 4), seq_vals[i], 4'hF, 0, 0, 0, "seq_w");
            axi_read(32'(i * 4), seq_vals[i], 2'b00, 0, "seq_r");
        end
        check_val("seq reg_out", reg_out, 128'hbeef0011_dead0011_abcd0001_0101ffff);

        axi_write(32'hC, 32'h600DF00D, 4'hF, 3, 0, 0, "w_first");
        axi_write(32'h0, 32'h1234ABCD, 4'hF, 0, 3, 0, "aw_first");
        check_val("order reg_out", reg_out,
                  {32'h600DF00D, 32'hdead0011, 32'habcd0001, 32'h1234ABCD});

        axi_write(32'h4, 32'habcd0001, 4'hF, 0, 0, 0, "strb_init");
        axi_write(32'h4, 32'h12345678, 4'b0101, 1, 0, 0, "strb_w");
        axi_read(32'h4, 32'hab340078, 2'b00, 0, "strb_r");

        axi_write(BASE + 32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, "oor_w");
        check_val("oor reg_out", reg_out, model_flat());
        axi_read(BASE + 32'h10, 32'h0, 2'b10, 0, "oor_r");

        fork
            axi_write(32'h8, 32'h55AA55AA, 4'hF, 0, 0, 5, "coll_w");
            axi_read(32'h8, 32'hdead0011, 2'b00, 5, "coll_r");
        join
        axi_read(32'h8, 32'h55AA55AA, 2'b00, 0, "coll_after");

        axi_write(32'h0, 32'h0101FFFF, 4'hF, 0, 0, 0, "rst_pre");
        bus.AWADDR  = 32'h0;
        bus.AWVALID = 1'b1;
        @(negedge clk);
        check_val("rst aw accept", bus.AWREADY, 1'b1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        @(negedge clk);
        check_val("got_addr ready", {bus.AWREADY, bus.WREADY}, 2'b01);
        rst = 1'b1;
        #1;
        check_val("mid rst ctrl", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, 5'b0);
        check_val("mid rst reg_out", reg_out, 128'h0);
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("no stray bvalid", {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);
            @(posedge clk); #1;
        end
        axi_read(32'h0, 32'h0, 2'b00, 0, "rst_r0");

        for (int t = 0; t < 40; t++) begin
            a = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rnd_w");
                check_val("rnd reg_out", reg_out, model_flat());
            end else begin
                rd_model(a, int'($urandom_range(0, 2)), "rnd_r");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4lite_gp_reg_slave.md
Name: axi4lite_gp_reg_slave

Overview:
AXI4-Lite slave register bank that terminates the general-purpose AXI4-Lite master port. It holds four 32-bit read/write registers at consecutive word offsets. Write address and write data are accepted independently, byte strobes are honoured, and out-of-range accesses return SLVERR. It sits directly downstream of the AXI4-Lite master in the axi4lite_gp block design and consumes its write and read bursts of length 1.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 32, address bus width.
C_NUM_REGS, 4, number of 32-bit registers; must be a power of 2, from 1 to 16.
C_BASE_ADDR, 32'h0000_0000, base address; bits below log2(C_NUM_REGS*4) must be zero.

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  write protection; ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte write strobes.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  read protection; ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg_out  out  32*C_NUM_REGS  flattened register contents; reg 0 in bits [31:0].

Behaviour:
- One clock domain. Reset is asynchronous and active-high (ARESET); release is synchronous to ACLK.
- Values while ARESET is high: every READY and VALID output = 0, BRESP = RRESP = 2'b00, RDATA = 0, all registers = 0.
- Write FSM states: W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP.
  - W_IDLE: AWREADY = 1, WREADY = 1.
  - W_IDLE, AW and W handshake in the same cycle: commit the write at that edge, go to W_RESP.
  - W_IDLE, AW handshake only: latch the address, go to W_GOT_ADDR. W_GOT_ADDR holds AWREADY = 0, WREADY = 1.
  - W_IDLE, W handshake only: latch data and strobe, go to W_GOT_DATA. W_GOT_DATA holds WREADY = 0, AWREADY = 1.
  - W_GOT_ADDR or W_GOT_DATA: on the missing handshake, commit the write and go to W_RESP.
  - W_RESP: BVALID = 1, both READYs = 0. On BREADY, go to W_IDLE.
  - BVALID asserts the cycle after the commit edge. Minimum write latency, AW/W handshake to BVALID: 1 cycle.
- Commit rule: index = addr[log2(C_NUM_REGS)+1:2]. In range means addr[ADDR_WIDTH-1:log2(C_NUM_REGS*4)] equals the same bits of C_BASE_ADDR.
  - In range: for each set WSTRB[i], reg[index][8i+7:8i] = WDATA byte i; BRESP = 2'b00.
  - Out of range: no register changes; BRESP = 2'b10 (SLVERR).
  - WSTRB = 4'b0000 in range: no change; BRESP = 2'b00.
  - addr[1:0] is ignored.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY = 1. On AR handshake, load RDATA/RRESP and go to R_DATA. RVALID is 1 the next cycle.
  - R_DATA: ARREADY = 0; RDATA and RRESP are held stable until RREADY, then go to R_IDLE.
  - Out-of-range read: RDATA = 32'h0, RRESP = 2'b10.
- Same-register collision: if a read is accepted on the same edge as a write commit to the same register, RDATA returns the pre-write value.
- Read and write channels run fully concurrently; neither stalls the other.
- No outstanding-transaction depth beyond 1 per channel.
- reg_out reflects registers combinationally from flops; it updates the cycle after commit.
- ARESET asserted mid-transaction: all state aborts to IDLE, pending responses are dropped, registers are cleared. The master must be reset with this block.
- AWPROT and ARPROT have no effect.

Decomposition:
- Package axi4lite_gp_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Write and read FSM state encodings.
  - Function for the address-to-index and range check.
- Sub-module axi4lite_gp_wr_ctrl: write-channel FSM plus address/data/strobe capture. It outputs a one-cycle commit strobe with index, data and strobe.
- The top holds the register array and the read FSM.

Test Plan:
- Reset, then sequential write/read of 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to offsets 0x0, 0x4, 0x8, 0xC with WSTRB = 4'hF -> each BRESP = 00, RDATA matches the written value, RRESP = 00, and reg_out equals {0xbeef0011, 0xdead0011, 0xabcd0001, 0x0101FFFF}.
- WVALID raised 3 cycles before AWVALID, then the reverse ordering -> both writes commit exactly once, and BVALID rises 1 cycle after the second handshake.
- Reg1 = 0xabcd0001, then write 0x12345678 with WSTRB = 4'b0101 -> read returns 0xab340078.
- Write 0xCAFEF00D to C_BASE_ADDR + 0x10 -> BRESP = 10, registers unchanged. Read of the same address -> RDATA = 0, RRESP = 10.
- BREADY and RREADY held low for 5 cycles -> BVALID, RVALID, BRESP and RDATA stay stable, and no new AW or AR is accepted. Same-edge write and read of reg2 (old value 0xdead0011, new value 0x55AA55AA) -> RDATA = 0xdead0011.
- ARESET pulsed while in W_GOT_ADDR with reg0 = 0x0101FFFF -> all VALID/READY outputs = 0 immediately. After release, reg0 reads 0 and no stray BVALID appears.
